alu_ctrl_seq: RTL

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with valid/ready handshake and optional multi-cycle multiply sequencing.
// Define ALU_CTRL_SEQ_MUL_EN to enable multiply decode and the MUL wait state.
module alu_ctrl_seq #(
    parameter int unsigned CTRL_W  = 4,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [5:0]        funct_i,
    input  logic [2:0]        aluop_i,
    output logic              ready_o,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              illegal_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef ALU_CTRL_SEQ_MUL_EN
        S_MUL  = 2'd1,
`endif
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    state_t            w_op_state;
    logic              w_ready;
    logic              w_accept;
    logic              w_consume;
    logic [3:0]        w_code;
    logic              w_illegal;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_illegal;
    logic              w_unused_funct;

    assign w_unused_funct = ^funct_i[5:4];

`ifdef ALU_CTRL_SEQ_MUL_EN
    logic       w_is_mul;
    logic [3:0] r_cnt;
`else
    localparam int unsigned lat_unused = MUL_LAT;
`endif

    always_comb begin
        w_code    = 4'b0000;
        w_illegal = 1'b0;
`ifdef ALU_CTRL_SEQ_MUL_EN
        w_is_mul  = 1'b0;
`endif
        case (aluop_i)
            3'b010: begin
                case (funct_i[3:0])
                    4'b0100: w_code = 4'b0000;
                    4'b0101: w_code = 4'b0001;
                    4'b0000: w_code = 4'b0010;
                    4'b0010: w_code = 4'b0110;
                    4'b1010: w_code = 4'b0111;
`ifdef ALU_CTRL_SEQ_MUL_EN
                    4'b1000: begin
                        w_code   = 4'b0011;
                        w_is_mul = 1'b1;
                    end
`endif
                    default: w_illegal = 1'b1;
                endcase
            end
            3'b110:  w_code = 4'b1010;
            3'b111:  w_code = 4'b1111;
            3'b000:  w_code = 4'b0010;
            3'b001:  w_code = 4'b1110;
            default: w_illegal = 1'b1;
        endcase
    end

`ifdef ALU_CTRL_SEQ_MUL_EN
    assign w_op_state = w_is_mul ? S_MUL : S_HOLD;
`else
    assign w_op_state = S_HOLD;
`endif

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (valid_i) w_next = w_op_state;
            end
`ifdef ALU_CTRL_SEQ_MUL_EN
            S_MUL: begin
                if (r_cnt == 4'd0) w_next = S_HOLD;
            end
`endif
            S_HOLD: begin
                // Consume and accept can share an edge, giving back-to-back results.
                w_ready = ready_i;
                if (ready_i) w_next = valid_i ? w_op_state : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept  = valid_i & w_ready;
    assign w_consume = (r_state == S_HOLD) & ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_ctrl    <= CTRL_W'(w_code);
            r_illegal <= w_illegal;
        end else if (w_consume) begin
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
        end
    end

`ifdef ALU_CTRL_SEQ_MUL_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_cnt <= '0;
        else if (w_accept)
            r_cnt <= w_is_mul ? 4'(MUL_LAT - 2) : 4'd0;
        else if ((r_state == S_MUL) && (r_cnt != 4'd0))
            r_cnt <= r_cnt - 4'd1;
    end

    assign busy_o = (r_state == S_MUL);
`else
    assign busy_o = 1'b0;
`endif

    assign ready_o   = w_ready;
    assign valid_o   = (r_state == S_HOLD);
    assign ALUCtrl_o = r_ctrl;
    assign illegal_o = r_illegal;

endmodule
